// File: rtl/toplevel_soc_spi_slave.sv
// SPI slave (mode 0, MSB first) with a CPU register port.
// SCLK, MOSI and SS_n are asynchronous and are oversampled on clk. The block
// holds one byte of receive buffering and one byte of transmit buffering.
// Register map: 0 rxdata, 1 txdata, 2 status (write clears), 3 control.
// SYNC_STAGES must be at least 2.
module toplevel_soc_spi_slave #(
  parameter int DATABITS    = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        MOSI,
  input  logic        SS_n,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic [2:0]  mem_addr,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  localparam int CNTW = $clog2(DATABITS);
  localparam int PADW = 16 - DATABITS;
  localparam logic [CNTW-1:0] CNT_ZERO = {CNTW{1'b0}};
  localparam logic [CNTW-1:0] CNT_ONE  = CNTW'(1);
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(DATABITS - 1);

  // Front end: synchronizer pipelines plus one delay flop for edge detection
  logic [SYNC_STAGES-1:0] sclk_pipe_r;
  logic [SYNC_STAGES-1:0] mosi_pipe_r;
  logic [SYNC_STAGES-1:0] ss_pipe_r;
  logic                   sclk_dly_r;
  logic                   ss_dly_r;

  logic sclk_sync_s, mosi_sync_s, ss_sync_s;
  logic sclk_rise_s, sclk_fall_s, ss_fall_s, ss_rise_s, selected_s;

  // Host strobe generation
  logic rd_strobe_q_r, wr_strobe_q_r;
  logic rd_strobe_s, wr_strobe_s;
  logic rd_rx_s, wr_tx_s, wr_stat_s, wr_ctrl_s;

  // Shift engine and buffers
  logic [CNTW-1:0]     bitcnt_r;
  logic [DATABITS-1:0] rx_shift_r;
  logic [DATABITS-1:0] rx_holding_r;
  logic [DATABITS-1:0] tx_shift_r;
  logic [DATABITS-1:0] tx_holding_r;
  logic [DATABITS-1:0] tx_shift_nxt_s;
  logic [DATABITS-1:0] rx_byte_s;
  logic                tx_primed_r;
  logic                load_s, shift_s, rx_bit_s, byte_done_s;

  // Flags, enables and outputs
  logic        rrdy_r, tur_r, toe_r, roe_r;
  logic        trdy_s, err_s;
  logic [5:0]  ctrl_r;
  logic [15:0] status_s;
  logic [15:0] control_s;
  logic [15:0] rd_mux_s;
  logic [15:0] data_to_cpu_r;
  logic        irq_r, miso_r, miso_oe_r;
  logic        unused_bits_s;

  assign sclk_sync_s = sclk_pipe_r[SYNC_STAGES-1];
  assign mosi_sync_s = mosi_pipe_r[SYNC_STAGES-1];
  assign ss_sync_s   = ss_pipe_r[SYNC_STAGES-1];
  assign sclk_rise_s = sclk_sync_s & ~sclk_dly_r;
  assign sclk_fall_s = ~sclk_sync_s & sclk_dly_r;
  assign ss_fall_s   = ~ss_sync_s & ss_dly_r;
  assign ss_rise_s   = ss_sync_s & ~ss_dly_r;
  assign selected_s  = ~ss_sync_s;

  assign rd_strobe_s = spi_select & ~read_n & ~rd_strobe_q_r;
  assign wr_strobe_s = spi_select & ~write_n & ~wr_strobe_q_r;
  assign rd_rx_s     = rd_strobe_s & (mem_addr == 3'd0);
  assign wr_tx_s     = wr_strobe_s & (mem_addr == 3'd1);
  assign wr_stat_s   = wr_strobe_s & (mem_addr == 3'd2);
  assign wr_ctrl_s   = wr_strobe_s & (mem_addr == 3'd3);

  assign trdy_s    = ~tx_primed_r;
  assign err_s     = roe_r | toe_r | tur_r;
  assign status_s  = {7'd0, err_s, rrdy_r, trdy_s, tur_r, toe_r, roe_r, 3'd0};
  assign control_s = {7'd0, ctrl_r, 3'd0};

  assign rx_bit_s    = sclk_rise_s & selected_s & ~ss_fall_s & ~ss_rise_s;
  assign byte_done_s = rx_bit_s & (bitcnt_r == CNT_LAST);
  assign rx_byte_s   = {rx_shift_r[DATABITS-2:0], mosi_sync_s};

  assign unused_bits_s = ^data_from_cpu[15:9];

  assign MISO          = miso_r;
  assign MISO_oe       = miso_oe_r;
  assign data_to_cpu   = data_to_cpu_r;
  assign irq           = irq_r;
  assign dataavailable = rrdy_r;
  assign readyfordata  = trdy_s;

  // Synchronize the asynchronous SPI pins and keep one delayed copy for edges
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_pipe_r <= {SYNC_STAGES{1'b0}};
      mosi_pipe_r <= {SYNC_STAGES{1'b0}};
      ss_pipe_r   <= {SYNC_STAGES{1'b1}};
      sclk_dly_r  <= 1'b0;
      ss_dly_r    <= 1'b1;
    end else begin
      sclk_pipe_r <= {sclk_pipe_r[SYNC_STAGES-2:0], SCLK};
      mosi_pipe_r <= {mosi_pipe_r[SYNC_STAGES-2:0], MOSI};
      ss_pipe_r   <= {ss_pipe_r[SYNC_STAGES-2:0], SS_n};
      sclk_dly_r  <= sclk_sync_s;
      ss_dly_r    <= ss_sync_s;
    end
  end

  // Decide between a transmit load and a transmit shift, and form the next shifter
  always_comb begin
    load_s         = 1'b0;
    shift_s        = 1'b0;
    tx_shift_nxt_s = tx_shift_r;
    if (ss_fall_s) begin
      load_s = 1'b1;
    end else if (sclk_fall_s && selected_s) begin
      if (bitcnt_r == CNT_ZERO) begin
        load_s = 1'b1;
      end else begin
        shift_s = 1'b1;
      end
    end else begin
      load_s  = 1'b0;
      shift_s = 1'b0;
    end
    if (load_s) begin
      tx_shift_nxt_s = tx_primed_r ? tx_holding_r : {DATABITS{1'b0}};
    end else if (shift_s) begin
      tx_shift_nxt_s = {tx_shift_r[DATABITS-2:0], 1'b0};
    end else begin
      tx_shift_nxt_s = tx_shift_r;
    end
  end

  // Read-back multiplexer for the CPU port
  always_comb begin
    rd_mux_s = 16'h0000;
    case (mem_addr)
      3'd0:    rd_mux_s = {{PADW{1'b0}}, rx_holding_r};
      3'd2:    rd_mux_s = status_s;
      3'd3:    rd_mux_s = control_s;
      default: rd_mux_s = 16'h0000;
    endcase
  end

  // Host strobe edge registers: a held access strobes every other cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_strobe_q_r <= 1'b0;
      wr_strobe_q_r <= 1'b0;
    end else begin
      rd_strobe_q_r <= rd_strobe_s;
      wr_strobe_q_r <= wr_strobe_s;
    end
  end

  // Receive shifter, bit counter and receive holding register
  always_ff @(posedge clk) begin
    if (reset) begin
      bitcnt_r     <= CNT_ZERO;
      rx_shift_r   <= {DATABITS{1'b0}};
      rx_holding_r <= {DATABITS{1'b0}};
    end else if (ss_fall_s || ss_rise_s) begin
      // Frame boundaries restart the count and drop any partial byte
      bitcnt_r   <= CNT_ZERO;
      rx_shift_r <= {DATABITS{1'b0}};
    end else if (rx_bit_s) begin
      bitcnt_r   <= bitcnt_r + CNT_ONE;
      rx_shift_r <= rx_byte_s;
      if (byte_done_s) begin
        rx_holding_r <= rx_byte_s;
      end
    end
  end

  // Transmit holding/priming and the transmit shifter
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_shift_r   <= {DATABITS{1'b0}};
      tx_holding_r <= {DATABITS{1'b0}};
      tx_primed_r  <= 1'b0;
    end else begin
      tx_shift_r <= tx_shift_nxt_s;
      // Both branches look at the pre-load primed bit, so they never collide
      if (load_s && tx_primed_r) begin
        tx_primed_r <= 1'b0;
      end else if (wr_tx_s && !tx_primed_r) begin
        tx_primed_r  <= 1'b1;
        tx_holding_r <= data_from_cpu[DATABITS-1:0];
      end
    end
  end

  // Status flags: set events take precedence over clears in the same cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rrdy_r <= 1'b0;
      roe_r  <= 1'b0;
      toe_r  <= 1'b0;
      tur_r  <= 1'b0;
    end else begin
      if (byte_done_s) begin
        rrdy_r <= 1'b1;
      end else if (rd_rx_s) begin
        rrdy_r <= 1'b0;
      end
      if (byte_done_s && rrdy_r && !rd_rx_s) begin
        roe_r <= 1'b1;
      end else if (wr_stat_s) begin
        roe_r <= 1'b0;
      end
      if (wr_tx_s && tx_primed_r) begin
        toe_r <= 1'b1;
      end else if (wr_stat_s) begin
        toe_r <= 1'b0;
      end
      if (load_s && !tx_primed_r) begin
        tur_r <= 1'b1;
      end else if (wr_stat_s) begin
        tur_r <= 1'b0;
      end
    end
  end

  // Interrupt enables
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_r <= 6'd0;
    end else if (wr_ctrl_s) begin
      ctrl_r <= data_from_cpu[8:3];
    end
  end

  // Registered outputs: read data, interrupt, MISO and its enable
  always_ff @(posedge clk) begin
    if (reset) begin
      data_to_cpu_r <= 16'h0000;
      irq_r         <= 1'b0;
      miso_r        <= 1'b0;
      miso_oe_r     <= 1'b0;
    end else begin
      data_to_cpu_r <= rd_mux_s;
      irq_r         <= |(status_s[8:3] & ctrl_r);
      // Next selected state is the stage feeding ss_sync
      miso_r        <= tx_shift_nxt_s[DATABITS-1] & ~ss_pipe_r[SYNC_STAGES-2];
      miso_oe_r     <= ~ss_pipe_r[SYNC_STAGES-2];
    end
  end

endmodule

// File: tb/tb_toplevel_soc_spi_slave.sv
// Directed bench for toplevel_soc_spi_slave: a behavioural SPI master and CPU
// host drive the pins; expected MISO and rx bytes go through scoreboard queues.
module tb_toplevel_soc_spi_slave;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        SCLK, MOSI, SS_n;
  logic        MISO, MISO_oe;
  logic [2:0]  mem_addr;
  logic        spi_select, read_n, write_n;
  logic [15:0] data_from_cpu;
  logic [15:0] data_to_cpu;
  logic        irq, dataavailable, readyfordata;

  int errors = 0;
  int checks = 0;

  logic [7:0]  exp_tx_q[$];
  logic [7:0]  exp_rx_q[$];

  toplevel_soc_spi_slave #(.DATABITS(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .SCLK(SCLK), .MOSI(MOSI), .SS_n(SS_n),
    .MISO(MISO), .MISO_oe(MISO_oe), .mem_addr(mem_addr),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
    .data_from_cpu(data_from_cpu), .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%04h expected=0x%04h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    mem_addr = a; data_from_cpu = d; spi_select = 1'b1; write_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    mem_addr = a; spi_select = 1'b1; read_n = 1'b0;
    @(negedge clk);
    d = data_to_cpu;
    spi_select = 1'b0; read_n = 1'b1;
  endtask

  task automatic ss_start();
    @(negedge clk);
    SS_n = 1'b0;
    tick(HALF);
  endtask

  task automatic ss_end();
    tick(HALF);
    SS_n = 1'b1;
    tick(HALF);
  endtask

  // Mode 0 master: data set while SCLK low, MISO sampled just before the rise
  task automatic spi_xfer(input logic [7:0] mosi_byte, input int nbits, output logic [7:0] miso_byte);
    miso_byte = 8'h00;
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_byte[7-i];
      tick(HALF);
      miso_byte = {miso_byte[6:0], MISO};
      SCLK = 1'b1;
      tick(HALF);
      SCLK = 1'b0;
    end
  endtask

  task automatic xfer_check(input string tag, input logic [7:0] mosi_byte);
    logic [7:0] got;
    logic [7:0] exp;
    spi_xfer(mosi_byte, 8, got);
    if (exp_tx_q.size() == 0) begin
      check({tag, "_txq_empty"}, 16'd0, 16'd1);
    end else begin
      exp = exp_tx_q.pop_front();
      check(tag, {8'h00, got}, {8'h00, exp});
    end
  endtask

  task automatic rx_check(input string tag);
    logic [15:0] d;
    logic [7:0]  exp;
    cpu_read(3'd0, d);
    if (exp_rx_q.size() == 0) begin
      check({tag, "_rxq_empty"}, 16'd0, 16'd1);
    end else begin
      exp = exp_rx_q.pop_front();
      check(tag, d, {8'h00, exp});
    end
  endtask

  task automatic status_check(input string tag, input logic [15:0] exp);
    logic [15:0] d;
    cpu_read(3'd2, d);
    check(tag, d, exp);
  endtask

  initial begin
    logic [7:0] dummy;
    reset = 1'b1; SCLK = 1'b0; MOSI = 1'b0; SS_n = 1'b1;
    mem_addr = 3'd0; spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
    data_from_cpu = 16'h0000;
    tick(4);
    reset = 1'b0;
    tick(2);

    // Reset state
    check("rst_readyfordata", {15'd0, readyfordata}, 16'd1);
    check("rst_dataavailable", {15'd0, dataavailable}, 16'd0);
    check("rst_irq", {15'd0, irq}, 16'd0);
    check("rst_miso_oe", {15'd0, MISO_oe}, 16'd0);
    check("rst_miso", {15'd0, MISO}, 16'd0);
    check("rst_data_to_cpu", data_to_cpu, 16'h0000);
    status_check("rst_status", 16'h0040);

    // Primed transfer: 0xA5 out, 0x3C in
    cpu_write(3'd1, 16'h00A5);
    check("prime_trdy_low", {15'd0, readyfordata}, 16'd0);
    exp_tx_q.push_back(8'hA5);
    exp_rx_q.push_back(8'h3C);
    ss_start();
    check("sel_miso_oe", {15'd0, MISO_oe}, 16'd1);
    xfer_check("miso_a5", 8'h3C);
    ss_end();
    check("desel_miso_oe", {15'd0, MISO_oe}, 16'd0);
    check("rrdy_set", {15'd0, dataavailable}, 16'd1);
    rx_check("rx_3c");
    check("rrdy_clr", {15'd0, dataavailable}, 16'd0);
    status_check("status_tur_after_frame", 16'h0160);
    cpu_write(3'd2, 16'h0000);
    status_check("status_cleared", 16'h0040);

    // One primed byte, two bytes under one SS: underrun and irq timing
    cpu_write(3'd3, 16'h0020);
    cpu_write(3'd1, 16'h0081);
    check("irq_idle", {15'd0, irq}, 16'd0);
    exp_tx_q.push_back(8'h81);
    exp_tx_q.push_back(8'h00);
    exp_rx_q.push_back(8'h34);
    ss_start();
    xfer_check("miso_81", 8'h12);
    tick(3);
    check("irq_before_lag", {15'd0, irq}, 16'd0);
    tick(1);
    check("irq_after_lag", {15'd0, irq}, 16'd1);
    xfer_check("miso_underrun_00", 8'h34);
    ss_end();
    status_check("status_tur_roe", 16'h01E8);
    rx_check("rx_34");
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd3, 16'h0000);
    tick(2);
    check("irq_cleared", {15'd0, irq}, 16'd0);

    // Overrun: 0x11 then 0x22 without a read
    exp_tx_q.push_back(8'h00);
    exp_tx_q.push_back(8'h00);
    exp_rx_q.push_back(8'h22);
    ss_start();
    xfer_check("miso_idle_a", 8'h11);
    ss_end();
    ss_start();
    xfer_check("miso_idle_b", 8'h22);
    ss_end();
    status_check("status_roe", 16'h01E8);
    cpu_write(3'd2, 16'h0000);
    status_check("status_roe_cleared", 16'h00C0);
    rx_check("rx_22");
    check("rrdy_clr_ovr", {15'd0, dataavailable}, 16'd0);

    // Aborted frame after 4 bits, then a full 0x5A frame
    cpu_write(3'd2, 16'h0000);
    ss_start();
    spi_xfer(8'hF0, 4, dummy);
    ss_end();
    check("abort_no_rrdy", {15'd0, dataavailable}, 16'd0);
    exp_tx_q.push_back(8'h00);
    exp_rx_q.push_back(8'h5A);
    ss_start();
    xfer_check("miso_after_abort", 8'h5A);
    ss_end();
    check("rrdy_after_abort", {15'd0, dataavailable}, 16'd1);
    rx_check("rx_5a");

    // Double tx write overflows; SCLK with SS_n high is ignored
    cpu_write(3'd2, 16'h0000);
    cpu_write(3'd1, 16'h0001);
    cpu_write(3'd1, 16'h0002);
    check("toe_trdy_low", {15'd0, readyfordata}, 16'd0);
    status_check("status_toe", 16'h0110);
    for (int i = 0; i < 8; i++) begin
      MOSI = i[0];
      tick(HALF);
      SCLK = 1'b1;
      tick(HALF);
      SCLK = 1'b0;
    end
    tick(HALF);
    check("desel_no_rrdy", {15'd0, dataavailable}, 16'd0);
    check("desel_still_primed", {15'd0, readyfordata}, 16'd0);
    check("desel_miso", {15'd0, MISO}, 16'd0);
    exp_tx_q.push_back(8'h01);
    exp_rx_q.push_back(8'h77);
    ss_start();
    xfer_check("miso_first_write", 8'h77);
    ss_end();
    rx_check("rx_77");
    status_check("status_final", 16'h0170);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
